mux_scanner: RTL and testbench

Sequencer that sits directly upstream of the 4:1 single-bit `mux` stage. It drives the mux select through the enabled channels, waits a programmable settle time on each, and samples the mux output. It then returns the four sampled bits as one parallel word with a one-cycle valid strobe. Software-style control is a start pulse plus a per-scan channel mask.

---
 rtl/mux_scanner.sv | 131 +++++++++++++
 tb/tb_mux_scanner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scanner.sv
`default_nettype none
// ============================================================================
// mux_scanner : steps a 4:1 mux select through masked channels, samples each
//               after DWELL cycles and returns the bits as one word.
// Rev 1.0
// ============================================================================
module mux_scanner #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       mux_in,
  output logic [1:0] sel,
  output logic [3:0] data,
  output logic       valid,
  output logic       busy
);

  localparam logic [4:0] CNT_LAST = 5'(DWELL - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] m_q, m_d;
  logic [3:0] sh_q, sh_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  logic       has_next;
  logic [1:0] next_sel;
  logic [3:0] sh_upd;

  always_comb begin
    has_next = 1'b0;
    next_sel = sel_q;
    // Descending walk so the nearest higher enabled channel is what remains
    for (int i = 3; i >= 0; i--) begin
      if (m_q[i] && (3'(i) > {1'b0, sel_q})) begin
        has_next = 1'b1;
        next_sel = 2'(i);
      end
    end
    sh_upd         = sh_q;
    sh_upd[sel_q]  = mux_in;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    sh_d    = sh_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mask != 4'd0) begin
            m_d     = mask;
            sh_d    = 4'd0;
            sel_d   = lowest_set(mask);
            cnt_d   = 5'd0;
            state_d = S_SCAN;
          end else begin
            data_d  = 4'd0;
            valid_d = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 5'd1;
        end else begin
          sh_d = sh_upd;
          if (has_next) begin
            sel_d = next_sel;
            cnt_d = 5'd0;
          end else begin
            data_d  = sh_upd;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      m_q     <= 4'd0;
      sh_q    <= 4'd0;
      sel_q   <= 2'd0;
      data_q  <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      sh_q    <= sh_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign sel   = sel_q;
  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = (state_q == S_SCAN);

endmodule
`default_nettype wire

// File: tb/tb_mux_scanner.sv
`default_nettype none
// ============================================================================
// tb_mux_scanner : two scanners (DWELL=2 and DWELL=1) on shared stimulus,
//                  checked each cycle against a schedule-based model.
// Rev 1.0
// ============================================================================
module tb_mux_scanner;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] mask, a;
  logic [1:0] sel0, sel1;
  logic [3:0] data0, data1;
  logic       valid0, valid1, busy0, busy1;
  logic       mux_in0, mux_in1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  assign mux_in0 = a[sel0];
  assign mux_in1 = a[sel1];

  mux_scanner #(.DWELL(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .mask(mask), .mux_in(mux_in0),
    .sel(sel0), .data(data0), .valid(valid0), .busy(busy0)
  );

  mux_scanner #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .mask(mask), .mux_in(mux_in1),
    .sel(sel1), .data(data1), .valid(valid1), .busy(busy1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted scan is a list of channels; channel k is sampled at
  // edge t0 + k*dwell, and the word is delivered when the last one is taken.
  logic       act[2];
  int         t0[2];
  int         ch[2][4];
  int         n[2];
  logic [3:0] smp[2];
  logic [1:0] es[2];
  logic [3:0] ed[2];
  logic       ev[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; es[i] = 2'd0; ed[i] = 4'd0; ev[i] = 1'b0;
      smp[i] = 4'd0; n[i] = 0; t0[i] = 0;
    end
  end

  always @(posedge clk) begin
    int dw, el, k;
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      dw = (i == 0) ? 2 : 1;
      if (rst) begin
        act[i] = 1'b0; es[i] = 2'd0; ed[i] = 4'd0; ev[i] = 1'b0;
      end else begin
        ev[i] = 1'b0;
        if (act[i]) begin
          el = cyc - t0[i];
          if (el % dw == 0) begin
            k = el / dw;
            smp[i][ch[i][k-1]] = a[ch[i][k-1]];
            if (k == n[i]) begin
              ed[i] = smp[i]; ev[i] = 1'b1; act[i] = 1'b0;
            end else begin
              es[i] = 2'(ch[i][k]);
            end
          end
        end else if (start) begin
          n[i] = 0;
          for (int j = 0; j < 4; j++) begin
            if (mask[j]) begin
              ch[i][n[i]] = j;
              n[i] = n[i] + 1;
            end
          end
          if (n[i] == 0) begin
            ed[i] = 4'd0; ev[i] = 1'b1;
          end else begin
            act[i] = 1'b1; t0[i] = cyc; smp[i] = 4'd0; es[i] = 2'(ch[i][0]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("m0_sel",   sel0,   es[0]);
      chk("m0_data",  data0,  ed[0]);
      chk("m0_valid", valid0, ev[0]);
      chk("m0_busy",  busy0,  act[0]);
      chk("m1_sel",   sel1,   es[1]);
      chk("m1_data",  data1,  ed[1]);
      chk("m1_valid", valid1, ev[1]);
      chk("m1_busy",  busy1,  act[1]);
    end
  end

  int seq_full[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int seq_part[4] = '{0, 0, 2, 2};
  int vcount;

  initial begin
    rst = 1'b1; start = 1'b0; mask = 4'd0; a = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_sel", sel0, 0);
    chk("rst_data", data0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_busy", busy0, 0);
    #1 rst = 1'b0;

    // Full scan, DWELL=2
    a = 4'b1010; mask = 4'b1111; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("full_sel", sel0, seq_full[i]);
      chk("full_nov", valid0, 0);
      if (i == 0) #1 start = 1'b0;
    end
    @(negedge clk);
    chk("full_valid", valid0, 1);
    chk("full_data", data0, 4'b1010);
    chk("full_busy", busy0, 0);

    // Partial mask
    #1 a = 4'b1111; mask = 4'b0101; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("part_sel", sel0, seq_part[i]);
      if (i == 0) #1 start = 1'b0;
    end
    @(negedge clk);
    chk("part_valid", valid0, 1);
    chk("part_data", data0, 4'b0101);

    // Empty mask
    #1 mask = 4'b0000; start = 1'b1;
    @(negedge clk);
    chk("empty_valid", valid0, 1);
    chk("empty_data", data0, 0);
    chk("empty_busy", busy0, 0);
    #1 start = 1'b0;
    @(negedge clk);
    chk("empty_vlow", valid0, 0);

    // Busy-ignore and back-to-back on the DWELL=1 instance
    #1 a = 4'b0110; mask = 4'b1111; start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("b2b_busy", busy1, 1);
      chk("b2b_nov", valid1, 0);
    end
    @(negedge clk);
    chk("b2b_valid", valid1, 1);
    chk("b2b_data", data1, 4'b0110);
    chk("b2b_gap", busy1, 0);
    @(negedge clk);
    chk("b2b_rebusy", busy1, 1);
    #1 start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset during channel 2
    #1 a = 4'b1111; mask = 4'b1111; start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst_ch2", sel0, 1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mrst_sel", sel0, 0);
    chk("mrst_data", data0, 0);
    chk("mrst_busy", busy0, 0);
    #1 rst = 1'b0;
    vcount = 0;
    repeat (12) begin
      @(negedge clk);
      vcount = vcount + int'(valid0);
    end
    chk("mrst_novalid", vcount, 0);

    // Reset together with start
    #1 rst = 1'b1; start = 1'b1; mask = 4'b1111;
    @(negedge clk);
    chk("rststart_busy0", busy0, 0);
    chk("rststart_busy1", busy1, 0);
    #1 rst = 1'b0; start = 1'b0;

    // Random traffic, including mid-scan changes of a and mask
    repeat (3000) begin
      @(negedge clk);
      #1;
      start = ($urandom_range(0, 3) == 0);
      mask  = 4'($urandom);
      if ($urandom_range(0, 9) < 3) a = 4'($urandom);
      rst   = ($urandom_range(0, 199) == 0);
    end
    #1 rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
